// File: rtl/mem_responder.sv
// Memory-side responder for the accumulator CPU bus: services rd/wr strobes
// from an internal RAM after a programmable number of wait states.
module mem_responder #(
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          err
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          wr_op_q;
  logic          armed_q;
  logic [DW-1:0] dout_q;
  logic          ready_q;
  logic          err_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic strobe_idle;
  logic strobe_one;
  logic strobe_both;

  assign strobe_idle = !rd && !wr;
  assign strobe_one  = rd ^ wr;
  assign strobe_both = rd && wr;

  assign dout  = dout_q;
  assign ready = ready_q;
  assign err   = err_q;

  // armed_q blocks a strobe that was already high across reset release:
  // a new request is only accepted once both strobes have been seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_op_q <= 1'b0;
      armed_q <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (strobe_idle) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (strobe_both) begin
            err_q <= 1'b1;
          end else if (strobe_one && armed_q) begin
            addr_q  <= addr;
            din_q   <= din;
            wr_op_q <= wr;
            cnt_q   <= WAIT_CNT;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (wr_op_q) begin
              mem_q[addr_q] <= din_q;
            end else begin
              dout_q <= mem_q[addr_q];
            end
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          state_q <= strobe_idle ? S_IDLE : S_HOLD;
        end

        S_HOLD: begin
          if (strobe_idle) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a cycle table on a WAIT=1 instance plus
// hand-written sequences on WAIT=0 and WAIT=4 instances.
module tb_mem_responder;

  logic       clk;
  logic       rst_v   [3];
  logic       rd_v    [3];
  logic       wr_v    [3];
  logic [4:0] addr_v  [3];
  logic [7:0] din_v   [3];
  logic [7:0] dout_v  [3];
  logic       ready_v [3];
  logic       err_v   [3];

  int checks;
  int errors;

  mem_responder #(.AW(5), .DW(8), .WAIT(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .rd(rd_v[0]), .wr(wr_v[0]),
    .din(din_v[0]), .dout(dout_v[0]), .ready(ready_v[0]), .err(err_v[0])
  );

  mem_responder #(.AW(5), .DW(8), .WAIT(0)) dut1 (
    .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .rd(rd_v[1]), .wr(wr_v[1]),
    .din(din_v[1]), .dout(dout_v[1]), .ready(ready_v[1]), .err(err_v[1])
  );

  mem_responder #(.AW(5), .DW(8), .WAIT(4)) dut2 (
    .clk(clk), .rst(rst_v[2]), .addr(addr_v[2]), .rd(rd_v[2]), .wr(wr_v[2]),
    .din(din_v[2]), .dout(dout_v[2]), .ready(ready_v[2]), .err(err_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic       ready;
    logic       err;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int k);
    rst_v[k] = 1'b1;
    rd_v[k]  = 1'b0;
    wr_v[k]  = 1'b0;
    tick();
    tick();
    rst_v[k] = 1'b0;
    tick();
    chk($sformatf("rst%0d_ready", k), 32'(ready_v[k]), 32'd0);
    chk($sformatf("rst%0d_dout", k), 32'(dout_v[k]), 32'd0);
  endtask

  // Request presented in cycle 0, held until ready, then strobes dropped.
  task automatic xfer(input int k, input logic is_wr, input logic [4:0] a,
                      input logic [7:0] d, input int exp_lat,
                      input logic [7:0] exp_dout, input string name);
    int c;
    c = 0;
    addr_v[k] = a;
    din_v[k]  = d;
    rd_v[k]   = !is_wr;
    wr_v[k]   = is_wr;
    do begin
      tick();
      c++;
    end while (!ready_v[k] && c < 40);
    chk({name, "_lat"}, 32'(c), 32'(exp_lat));
    chk({name, "_dout"}, 32'(dout_v[k]), 32'(exp_dout));
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
    tick();
    chk({name, "_ready_clr"}, 32'(ready_v[k]), 32'd0);
  endtask

  initial begin
    int pulses;
    int first;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      rst_v[k]  = 1'b1;
      rd_v[k]   = 1'b0;
      wr_v[k]   = 1'b0;
      addr_v[k] = 5'd0;
      din_v[k]  = 8'h00;
    end

    //          rst   rd    wr    addr   din    ready err   dout
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'd3, 8'hA5, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'd3, 8'hA5, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b0, 8'hA5};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 8'hA5};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 8'hA5};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 5'd7, 8'hFF, 1'b0, 1'b1, 8'hA5};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 5'd7, 8'hFF, 1'b0, 1'b1, 8'hA5};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 5'd7, 8'hFF, 1'b0, 1'b0, 8'hA5};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 8'hA5};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 8'hA5};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 5'd7, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 8'h00};

    // Row i drives cycle i; outputs compared are those of cycle i+1.
    for (int i = 0; i < 22; i++) begin
      rst_v[0]  = tbl[i].rst;
      rd_v[0]   = tbl[i].rd;
      wr_v[0]   = tbl[i].wr;
      addr_v[0] = tbl[i].addr;
      din_v[0]  = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_ready", i), 32'(ready_v[0]), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_err", i), 32'(err_v[0]), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_dout", i), 32'(dout_v[0]), 32'(tbl[i].dout));
    end

    // Held read of address 3 for 10 cycles with addr switched to 5 in cycle 1.
    rd_v[0]   = 1'b1;
    addr_v[0] = 5'd3;
    pulses    = 0;
    first     = -1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (ready_v[0]) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c == 1) addr_v[0] = 5'd5;
      if (c == 10) rd_v[0] = 1'b0;
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_ready_cycle", 32'(first), 32'd3);
    chk("held_dout", 32'(dout_v[0]), 32'hA5);
    xfer(0, 1'b0, 5'd5, 8'h00, 3, 8'h00, "held_reread5");

    // WAIT=0 instance.
    do_reset(1);
    xfer(1, 1'b0, 5'd0, 8'h00, 2, 8'h00, "w0_rd0");
    xfer(1, 1'b1, 5'd4, 8'h77, 2, 8'h00, "w0_wr4");
    xfer(1, 1'b0, 5'd4, 8'h00, 2, 8'h77, "w0_rd4");

    // WAIT=4 instance.
    do_reset(2);
    xfer(2, 1'b0, 5'd0, 8'h00, 6, 8'h00, "w4_rd0");
    xfer(2, 1'b1, 5'd9, 8'h5A, 6, 8'h00, "w4_wr9");
    xfer(2, 1'b0, 5'd9, 8'h00, 6, 8'h5A, "w4_rd9");

    // Reset asserted in cycle 2 of a WAIT=4 write.
    wr_v[2]   = 1'b1;
    addr_v[2] = 5'd9;
    din_v[2]  = 8'h3C;
    tick();
    chk("midwr_c1_ready", 32'(ready_v[2]), 32'd0);
    tick();
    rst_v[2] = 1'b1;
    tick();
    chk("midwr_rst_ready", 32'(ready_v[2]), 32'd0);
    chk("midwr_rst_dout", 32'(dout_v[2]), 32'h00);
    rst_v[2] = 1'b0;
    wr_v[2]  = 1'b0;
    pulses   = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ready_v[2]) pulses++;
    end
    chk("midwr_no_ready", 32'(pulses), 32'd0);
    xfer(2, 1'b0, 5'd9, 8'h00, 6, 8'h00, "midwr_rd9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the accumulator CPU's memory bus. It receives the `rd`/`wr` strobes, address and write data driven by the control unit and datapath, and services them from an internal synchronous RAM. It inserts a programmable number of wait states and signals completion with a one-cycle `ready` pulse. It sits between the CPU datapath/control unit and the system memory map; the control unit holds its strobe until `ready`, then drops it.

## Interface
- `AW`, default 5: address width; RAM depth is 2^AW words.
- `DW`, default 8: data word width.
- `WAIT`, default 1: wait states inserted before each access; legal range 0..15.

- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `addr`, input, AW: word address from the CPU.
- `rd`, input, 1: read strobe, level-held by the CPU until `ready`.
- `wr`, input, 1: write strobe, level-held by the CPU until `ready`.
- `din`, input, DW: write data from the CPU (`dout_en` path).
- `dout`, output, DW: registered read data. Holds the last read value.
- `ready`, output, 1: one-cycle completion pulse for the accepted transaction.
- `err`, output, 1: one-cycle pulse when `rd` and `wr` are both high in IDLE.

## Operation
- States: IDLE, WAIT, DONE, HOLD. The state encoding is internal; outputs are registered.
- **IDLE**
  - `rd`^`wr` (exactly one high): capture `addr`, `din` and the op; load `cnt`=WAIT; go to WAIT.
  - `rd`&`wr`: set `err`=1 for the next cycle. No capture, no RAM access; stay in IDLE.
  - Neither strobe high: stay in IDLE.
- **WAIT**
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0, captured op is write: `mem[a]` <= `d`. Then `ready`<=1 and go to DONE.
  - `cnt`=0, captured op is read: `dout` <= `mem[a]`. Then `ready`<=1 and go to DONE.
- **DONE**
  - `ready` is high in this cycle only; it is cleared at the exiting edge.
  - Both strobes low: go to IDLE. Otherwise go to HOLD.
- **HOLD**
  - Wait until `rd`=0 and `wr`=0, then go to IDLE.
  - A new request requires the strobes to deassert and be re-seen in IDLE; a strobe held continuously never produces a second access.
- Input changes on `addr`, `din`, `rd` and `wr` after capture are ignored until IDLE. Dropping a strobe early does not abort the access.
- `dout` changes only on a completed read (or on reset). Writes leave `dout` unchanged.
- No address wrap is needed: `addr` is exactly AW bits and every address is valid.

## Timing
- Reset (`rst` high at an edge) forces:
  - state IDLE, `cnt`=0;
  - `ready`=0, `err`=0, `dout`=0;
  - all RAM words cleared to 0.
- `rst` takes priority over every other event.
- Reset during WAIT aborts the transaction: no write lands and no `ready` is issued.
- Latency: request first high in cycle 0 (sampled at the end of cycle 0) gives `ready`=1 in cycle WAIT+2.
  - With WAIT=0, `ready` is in cycle 2.
  - With WAIT=1, `ready` is in cycle 3.
- Read data is valid on `dout` in the same cycle `ready` is high, and stays valid afterwards.
- `err` is high in cycle 1 for a conflicting request in cycle 0. It repeats every cycle the conflict persists in IDLE.
- Minimum spacing between accepted requests: WAIT+3 cycles. That is WAIT+1 cycles in WAIT, 1 in DONE, and 1 in IDLE with strobes low, then the new request.
- Write visibility: a read accepted after a write's `ready` returns the new data.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with `rd`=1.
  - Required: `ready`=0, `err`=0, `dout`=0 throughout, and no transaction after release until `rd` toggles low then high.
- **Write then read, WAIT=1:**
  - Stimulus: `wr`=1, `addr`=3, `din`=0xA5 until `ready`, then strobes low. Then `rd`=1, `addr`=3.
  - Required: `ready` in cycle 3 of each request; `dout`=0xA5 in the read's `ready` cycle.
- **Latency sweep:**
  - Stimulus: with WAIT=0 and then WAIT=4, read `addr`=0 after reset.
  - Required: `ready` in cycle 2 and cycle 6 respectively; `dout`=0x00.
- **Strobe conflict:**
  - Stimulus: `rd`=`wr`=1 for 2 cycles with `addr`=7, `din`=0xFF.
  - Required: `err` high in cycles 1–2, `ready` never asserts, and a subsequent read of 7 returns 0x00.
- **Held strobe / input change:**
  - Stimulus: `rd`=1 on `addr`=3 held for 10 cycles, with `addr` switched to 5 in cycle 1.
  - Required: exactly one `ready` pulse, `dout` from address 3, FSM parked in HOLD until `rd` drops.
- **Reset mid-write:**
  - Stimulus: WAIT=4, write 0x5A to `addr`=9, assert `rst` in cycle 2.
  - Required: no `ready`, and a later read of 9 returns 0x00.
